// File: rtl/sincos_taylor_pkg.sv
// sincos_taylor_pkg
// Shared types and elaboration-time constants for the sincos_taylor block.
//   state_t     : controller state encoding
//   C_MAX_TERMS : upper bound on the number of odd Taylor terms
//   coef_table  : quantised coefficients c_k = (-1)^k (pi/2)^(2k+1)/(2k+1)!
//                 in Q2.(tapwidth-2), round-to-nearest, packed 32 bits per entry
//                 (entry k at bits [32k +: 32], sign-extended).
package sincos_taylor_pkg;

  localparam int C_MAX_TERMS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLD,
    S_SQUARE,
    S_HORNER,
    S_FINAL,
    S_RESCALE,
    S_OUTPUT
  } state_t;

  function automatic logic [C_MAX_TERMS*32-1:0] coef_table(input int tapwidth,
                                                           input int num_terms);
    logic [C_MAX_TERMS*32-1:0] tbl;
    real half_pi;
    real scale;
    real pw;
    real fact;
    real term;
    real v;
    int  q_val;
    tbl     = '0;
    half_pi = 1.5707963267948966;
    scale   = 1.0;
    for (int i = 0; i < tapwidth - 2; i++) scale = scale * 2.0;
    pw   = half_pi;
    fact = 1.0;
    for (int k = 0; k < C_MAX_TERMS; k++) begin
      if (k < num_terms) begin
        term = pw / fact;
        if ((k % 2) == 1) term = -term;
        v = term * scale;
        // $rtoi truncates toward zero, so round the magnitude
        if (v >= 0.0) q_val = $rtoi(v + 0.5);
        else          q_val = -$rtoi(-v + 0.5);
        tbl[k*32 +: 32] = q_val;
      end
      pw   = pw * half_pi * half_pi;
      fact = fact * real'((2*k + 2) * (2*k + 3));
    end
    return tbl;
  endfunction

endpackage

// File: rtl/sincos_quadrant_fold.sv
// sincos_quadrant_fold
// Registered fold of a full-circle phase into the first quadrant.
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear (block disabled)
//   load         : capture a new fold result
//   phase, mode  : unsigned phase (2^W = 2*pi), 0 = sine / 1 = cosine
//   x            : unsigned Q1.(W-2) first-quadrant argument, 1.0 exact
//   negate       : result must be negated (quadrants 2 and 3)
module sincos_quadrant_fold #(
  parameter int G_DWIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clr,
  input  logic                load,
  input  logic [G_DWIDTH-1:0] phase,
  input  logic                mode,
  output logic [G_DWIDTH-2:0] x,
  output logic                negate
);

  localparam int D = G_DWIDTH;
  localparam logic [D-2:0] ONE = {1'b1, {(D-2){1'b0}}};

  logic [1:0]   quad;
  logic [D-2:0] frac;
  logic [D-2:0] x_n;

  // cos(t) = sin(t + pi/2): cosine just advances the quadrant by one
  assign quad = phase[D-1:D-2] + {1'b0, mode};
  assign frac = {1'b0, phase[D-3:0]};
  assign x_n  = quad[0] ? (ONE - frac) : frac;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x      <= '0;
      negate <= 1'b0;
    end else if (clr) begin
      x      <= '0;
      negate <= 1'b0;
    end else if (load) begin
      x      <= x_n;
      negate <= quad[1];
    end
  end

endmodule

// File: rtl/sincos_taylor.sv
// sincos_taylor
// Iterative sine/cosine: quadrant fold, Horner evaluation of the odd Taylor
// series of sin(pi*x/2) on one shared multiplier, rescale, saturate, sign.
//   clk, reset_n            : clock, async active-low reset
//   enable                  : low = synchronous clear to idle
//   din, din_mode           : phase (2^G_DWIDTH = 2*pi), 0 = sine / 1 = cosine
//   din_valid / din_ready   : input handshake
//   dout, dout_mode         : signed Q1.(G_DWIDTH-1) result and its mode
//   dout_valid / dout_ready : output handshake
// Build option: SINCOS_TAYLOR_ROUND_EN selects round-half-up in the final
// rescale instead of truncation (latency unchanged).
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_IDLE    | din_ready high, waiting for an input handshake
// S_FOLD    | fold phase into first-quadrant x and negate flag
// S_SQUARE  | x2 = x*x, acc = highest coefficient, load term counter
// S_HORNER  | acc = acc*x2 + c_k, k counts down to 0 (N-1 cycles)
// S_FINAL   | p = acc*x
// S_RESCALE | shift, saturate, apply sign, raise dout_valid
// S_OUTPUT  | hold result until the output handshake
module sincos_taylor
  import sincos_taylor_pkg::*;
#(
  parameter int G_DWIDTH    = 16,
  parameter int G_TAPWIDTH  = 18,
  parameter int G_NUM_TERMS = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [G_DWIDTH-1:0] din,
  input  logic                din_mode,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [G_DWIDTH-1:0] dout,
  output logic                dout_mode,
  output logic                dout_valid,
  input  logic                dout_ready
);

  localparam int D  = G_DWIDTH;
  localparam int T  = G_TAPWIDTH;
  localparam int P  = G_TAPWIDTH + G_DWIDTH;
  localparam int SH = G_DWIDTH - 2;

  localparam logic [C_MAX_TERMS*32-1:0] C_TABLE = coef_table(T, G_NUM_TERMS);
  localparam logic signed [T-1:0] C_TOP   = C_TABLE[32*(G_NUM_TERMS-1) +: T];
  localparam logic [2:0]          K_START = 3'(G_NUM_TERMS - 2);

  localparam logic signed [P-1:0] ACC_MAX = {{(P-T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [P-1:0] ACC_MIN = {{(P-T+1){1'b1}}, {(T-1){1'b0}}};
  localparam logic signed [P-1:0] OUT_MAX = {{(P-D+1){1'b0}}, {(D-1){1'b1}}};
`ifdef SINCOS_TAYLOR_ROUND_EN
  localparam logic signed [P-1:0] RND = P'(1) << (T-4);
`else
  localparam logic signed [P-1:0] RND = '0;
`endif

  state_t                state;
  logic [D-1:0]          phase_r;
  logic                  mode_r;
  logic [2:0]            k;
  logic [D-2:0]          x2;
  logic signed [T-1:0]   acc;
  logic signed [P-1:0]   p;

  logic [D-2:0]          x;
  logic                  negate;

  logic [2*D-3:0]        sq;
  logic signed [T-1:0]   coef_k;
  logic signed [P-1:0]   prod_h;
  logic signed [P-1:0]   sum_h;
  logic signed [T-1:0]   acc_next;
  logic signed [P-1:0]   prod_f;
  logic signed [P-1:0]   p_sh;
  logic signed [P-1:0]   p_mag;
  logic signed [P-1:0]   p_res;

  sincos_quadrant_fold #(.G_DWIDTH(D)) u_fold (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (!enable),
    .load    (state == S_FOLD),
    .phase   (phase_r),
    .mode    (mode_r),
    .x       (x),
    .negate  (negate)
  );

  assign sq     = (2*D-2)'(x) * (2*D-2)'(x);
  assign coef_k = C_TABLE[32*k +: T];
  assign prod_h = P'(acc) * P'($signed({1'b0, x2}));
  assign sum_h  = (prod_h >>> SH) + P'(coef_k);
  assign prod_f = P'(acc) * P'($signed({1'b0, x}));
  assign p_sh   = (p + RND) >>> (T-3);

  always_comb begin
    acc_next = T'(sum_h);
    if (sum_h > ACC_MAX)      acc_next = T'(ACC_MAX);
    else if (sum_h < ACC_MIN) acc_next = T'(ACC_MIN);
  end

  // x = 1.0 gives a polynomial value slightly above 1.0, hence the clamp
  always_comb begin
    p_mag = p_sh;
    if (p_sh > OUT_MAX)       p_mag = OUT_MAX;
    else if (p_sh < -OUT_MAX) p_mag = -OUT_MAX;
    p_res = negate ? -p_mag : p_mag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      din_ready  <= 1'b0;
      dout       <= '0;
      dout_mode  <= 1'b0;
      dout_valid <= 1'b0;
      phase_r    <= '0;
      mode_r     <= 1'b0;
      k          <= '0;
      x2         <= '0;
      acc        <= '0;
      p          <= '0;
    end else if (!enable) begin
      state      <= S_IDLE;
      din_ready  <= 1'b0;
      dout       <= '0;
      dout_mode  <= 1'b0;
      dout_valid <= 1'b0;
      phase_r    <= '0;
      mode_r     <= 1'b0;
      k          <= '0;
      x2         <= '0;
      acc        <= '0;
      p          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          din_ready <= 1'b1;
          if (din_valid && din_ready) begin
            phase_r   <= din;
            mode_r    <= din_mode;
            din_ready <= 1'b0;
            state     <= S_FOLD;
          end
        end
        S_FOLD: state <= S_SQUARE;
        S_SQUARE: begin
          x2    <= (D-1)'(sq >> SH);
          acc   <= C_TOP;
          k     <= K_START;
          state <= S_HORNER;
        end
        S_HORNER: begin
          acc <= acc_next;
          if (k == 3'd0) state <= S_FINAL;
          else           k     <= k - 3'd1;
        end
        S_FINAL: begin
          p     <= prod_f;
          state <= S_RESCALE;
        end
        S_RESCALE: begin
          dout       <= D'(p_res);
          dout_mode  <= mode_r;
          dout_valid <= 1'b1;
          state      <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sincos_taylor.sv
// tb_sincos_taylor
// Directed bench for sincos_taylor (G_DWIDTH=16, G_TAPWIDTH=18, N=5).
module tb_sincos_taylor;

  localparam int NT  = 5;
  localparam int LAT = NT + 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] din = '0;
  logic        din_mode = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [15:0] dout;
  logic        dout_mode;
  logic        dout_valid;
  logic        dout_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sincos_taylor #(
    .G_DWIDTH   (16),
    .G_TAPWIDTH (18),
    .G_NUM_TERMS(NT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .din        (din),
    .din_mode   (din_mode),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_mode  (dout_mode),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [15:0] obs, input logic [15:0] exp,
                         input int tol);
    int err;
    err = int'($signed(obs)) - int'($signed(exp));
    if (err < 0) err = -err;
    n_checks++;
    assert ((err <= tol) === 1'b1) else begin
      n_errors++;
      $error("FAIL %s: observed %04h expected %04h +/-%0d", tag, obs, exp, tol);
    end
  endtask

  // present one sample at a negedge and return #1 after its acceptance edge
  task automatic start(input logic [15:0] ph, input logic m);
    int w;
    w = 0;
    @(negedge clk);
    while (din_ready !== 1'b1 && w < 30) begin
      @(negedge clk);
      w++;
    end
    chk("din_ready_wait", {31'd0, din_ready}, 32'd1);
    din       = ph;
    din_mode  = m;
    din_valid = 1'b1;
    @(posedge clk);
    #1 din_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (dout_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1 dout_ready = 1'b0;
    chk("valid_low_after_hs", {31'd0, dout_valid}, 32'd0);
    chk("ready_after_hs", {31'd0, din_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [15:0] ph, input logic m,
                     input logic [15:0] exp, input int tol);
    int lat;
    start(ph, m);
    wait_result(lat);
    chk({tag, "_latency"}, 32'(lat), 32'(LAT));
    chk_tol({tag, "_dout"}, dout, exp, tol);
    chk({tag, "_mode"}, {31'd0, dout_mode}, {31'd0, m});
    handshake();
  endtask

  initial begin
    int  lat;
    logic seen;

    // reset state
    #12;
    chk("rst_din_ready", {31'd0, din_ready}, 32'd0);
    chk("rst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("rst_dout", {16'd0, dout}, 32'd0);
    chk("rst_dout_mode", {31'd0, dout_mode}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ready_before_edge", {31'd0, din_ready}, 32'd0);
    @(posedge clk);
    #1 chk("ready_first_edge", {31'd0, din_ready}, 32'd1);

    // sine points
    run("sin_0000", 16'h0000, 1'b0, 16'h0000, 0);
    run("sin_4000", 16'h4000, 1'b0, 16'h7FFF, 0);
    run("sin_8000", 16'h8000, 1'b0, 16'h0000, 1);
    run("sin_C000", 16'hC000, 1'b0, 16'h8001, 0);
    run("sin_2000", 16'h2000, 1'b0, 16'h5A82, 2);
    run("sin_1000", 16'h1000, 1'b0, 16'h30FC, 3);
    run("sin_E000", 16'hE000, 1'b0, 16'hA57E, 2);
    // cosine points
    run("cos_0000", 16'h0000, 1'b1, 16'h7FFF, 0);
    run("cos_4000", 16'h4000, 1'b1, 16'h0000, 1);
    run("cos_2000", 16'h2000, 1'b1, 16'h5A82, 2);
    run("cos_8000", 16'h8000, 1'b1, 16'h8001, 0);

    // backpressure, with a pending din_valid that must wait
    start(16'hC000, 1'b0);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'(LAT));
    chk("bp_dout", {16'd0, dout}, 32'h8001);
    din       = 16'h2000;
    din_mode  = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_dout", {16'd0, dout}, 32'h8001);
      chk("bp_hold_valid", {31'd0, dout_valid}, 32'd1);
      chk("bp_hold_ready", {31'd0, din_ready}, 32'd0);
    end
    handshake();
    @(posedge clk);
    #1 din_valid = 1'b0;
    chk("bp_pending_accepted", {31'd0, din_ready}, 32'd0);
    wait_result(lat);
    chk("bp2_latency", 32'(lat), 32'(LAT));
    chk_tol("bp2_dout", dout, 16'h5A82, 2);
    chk("bp2_mode", {31'd0, dout_mode}, 32'd0);
    handshake();

    // reset pulse in the middle of the Horner loop
    run("pre_rst", 16'h8000, 1'b1, 16'h8001, 0);
    start(16'h1000, 1'b0);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_din_ready", {31'd0, din_ready}, 32'd0);
    chk("midrst_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("midrst_dout", {16'd0, dout}, 32'd0);
    chk("midrst_dout_mode", {31'd0, dout_mode}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dout_valid === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_output", {31'd0, seen}, 32'd0);
    run("post_rst", 16'h1000, 1'b0, 16'h30FC, 3);

    // enable low in the middle of the Horner loop
    run("pre_en", 16'h0000, 1'b1, 16'h7FFF, 0);
    start(16'h2000, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_din_ready", {31'd0, din_ready}, 32'd0);
    chk("en_dout_valid", {31'd0, dout_valid}, 32'd0);
    chk("en_dout", {16'd0, dout}, 32'd0);
    chk("en_dout_mode", {31'd0, dout_mode}, 32'd0);
    @(negedge clk);
    enable = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (dout_valid === 1'b1) seen = 1'b1;
    end
    chk("en_no_output", {31'd0, seen}, 32'd0);
    run("post_en", 16'h1000, 1'b1, 16'h7642, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
